// File: rtl/ppu_vram_block_loader_pkg.sv
// Shared constants for the PPU VRAM block loader: palette defaults, loader
// state encoding and the tag index width helper.
package ppu_pkg;

   localparam logic [15:0] PPU_PALETTE_BASE    = 16'h3F00;
   localparam int          PPU_PALETTE_ENTRIES = 32;

   typedef logic [1:0] loader_state_t;

   localparam loader_state_t ST_IDLE  = 2'd0;
   localparam loader_state_t ST_ISSUE = 2'd1;
   localparam loader_state_t ST_DRAIN = 2'd2;

   // A single-entry load still needs a one-bit tag.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ppu_vram_block_loader_if.sv
// Sequencer/VRAM-facing bundle of the block loader. The loader uses the slave
// modport; the sequencer plus VRAM read port side uses master.
interface ppu_vram_block_loader_if #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 8,
   parameter int NUM_ENTRIES = 32
);
   logic                          start;
   logic                          abort;
   logic                          busy;
   logic                          done;
   logic [ADDR_W-1:0]             vram_addr;
   logic                          vram_rd;
   logic [DATA_W-1:0]             vram_data_in;
   logic [NUM_ENTRIES*DATA_W-1:0] entries;

   modport master (
      output start, abort, vram_data_in,
      input  busy, done, vram_addr, vram_rd, entries
   );

   modport slave (
      input  start, abort, vram_data_in,
      output busy, done, vram_addr, vram_rd, entries
   );
endinterface

// File: rtl/ppu_vram_block_loader_tag_pipe.sv
// ppu_read_tag_pipe: LAT-stage valid+index shift register that tracks which
// entry each outstanding VRAM read belongs to; synchronous flush kills all.
module ppu_read_tag_pipe #(
   parameter int LAT   = 1,
   parameter int IDX_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_flush,
   input  logic             i_valid,
   input  logic [IDX_W-1:0] i_idx,
   output logic             o_valid,
   output logic [IDX_W-1:0] o_idx
);

   logic [LAT-1:0]   r_valid;
   logic [IDX_W-1:0] r_idx [LAT];
   logic [LAT-1:0]   w_valid_d;
   logic [IDX_W-1:0] w_idx_d [LAT];

   genvar gi;
   generate
      for (gi = 0; gi < LAT; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            assign w_valid_d[gi] = i_valid;
            assign w_idx_d[gi]   = i_idx;
         end else begin : g_tail
            assign w_valid_d[gi] = r_valid[gi-1];
            assign w_idx_d[gi]   = r_idx[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= '0;
         for (int i = 0; i < LAT; i++) r_idx[i] <= '0;
      end else begin
         r_valid <= i_flush ? '0 : w_valid_d;
         for (int i = 0; i < LAT; i++) r_idx[i] <= w_idx_d[i];
      end
   end

   assign o_valid = r_valid[LAT-1];
   assign o_idx   = r_idx[LAT-1];

endmodule

// File: rtl/ppu_vram_block_loader.sv
// Bulk VRAM-to-register loader: reads NUM_ENTRIES bytes from BASE_ADDR into a
// flat entry bus. Optional PALETTE_MIRROR_EN maps slots 16/20/24/28 onto 0/4/8/12.
module ppu_vram_block_loader
   import ppu_pkg::*;
#(
   parameter int                ADDR_W      = 16,
   parameter int                DATA_W      = 8,
   parameter int                NUM_ENTRIES = PPU_PALETTE_ENTRIES,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = PPU_PALETTE_BASE,
   parameter int                READ_LAT    = 1
) (
   input logic                   clk,
   input logic                   rst,
   ppu_vram_block_loader_if.slave bus
);

   localparam int               IDX_W    = idx_width(NUM_ENTRIES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

   loader_state_t     r_state;
   logic [IDX_W-1:0]  r_issue_idx;
   logic [ADDR_W-1:0] r_vram_addr;
   logic              r_vram_rd;
   logic              r_done;
   logic [DATA_W-1:0] r_entries [NUM_ENTRIES];

   logic              w_flush;
   logic              w_cap_valid;
   logic [IDX_W-1:0]  w_cap_idx;

   assign w_flush = bus.abort && (r_state != ST_IDLE);

   ppu_read_tag_pipe #(
      .LAT   (READ_LAT),
      .IDX_W (IDX_W)
   ) u_tag_pipe (
      .clk     (clk),
      .rst     (rst),
      .i_flush (w_flush),
      .i_valid (r_vram_rd),
      .i_idx   (r_issue_idx),
      .o_valid (w_cap_valid),
      .o_idx   (w_cap_idx)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_issue_idx <= '0;
         r_vram_addr <= '0;
         r_vram_rd   <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_state     <= ST_ISSUE;
                  r_issue_idx <= '0;
                  r_vram_addr <= BASE_ADDR;
                  r_vram_rd   <= 1'b1;
               end
            end
            ST_ISSUE: begin
               if (bus.abort) begin
                  r_state   <= ST_IDLE;
                  r_vram_rd <= 1'b0;
               end else if (r_issue_idx == LAST_IDX) begin
                  r_state   <= ST_DRAIN;
                  r_vram_rd <= 1'b0;
               end else begin
                  r_issue_idx <= r_issue_idx + 1'b1;
                  r_vram_addr <= r_vram_addr + 1'b1;
               end
            end
            ST_DRAIN: begin
               // Abort beats a coinciding final capture: no done pulse.
               if (bus.abort) begin
                  r_state <= ST_IDLE;
               end else if (w_cap_valid && (w_cap_idx == LAST_IDX)) begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_ENTRIES; i++) r_entries[i] <= '0;
      end else if (w_cap_valid) begin
         r_entries[w_cap_idx] <= bus.vram_data_in;
      end
   end

   assign bus.busy      = (r_state != ST_IDLE);
   assign bus.done      = r_done;
   assign bus.vram_addr = r_vram_addr;
   assign bus.vram_rd   = r_vram_rd;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_out
`ifdef PALETTE_MIRROR_EN
         if ((NUM_ENTRIES >= 32) && (gi >= 16) && (gi <= 28) && ((gi % 4) == 0)) begin : g_mirror
            assign bus.entries[gi*DATA_W +: DATA_W] = r_entries[gi-16];
         end else begin : g_direct
            assign bus.entries[gi*DATA_W +: DATA_W] = r_entries[gi];
         end
`else
         assign bus.entries[gi*DATA_W +: DATA_W] = r_entries[gi];
`endif
      end
   endgenerate

endmodule

// File: tb/tb_ppu_vram_block_loader.sv
// Randomized bench for ppu_vram_block_loader: a palette-default instance and a
// small wrapping, long-latency instance, checked cycle by cycle against a load model.
module tb_ppu_vram_block_loader;

   localparam int          N0 = 32;
   localparam int          L0 = 1;
   localparam logic [15:0] B0 = 16'h3F00;
   localparam int          N1 = 4;
   localparam int          L1 = 3;
   localparam logic [15:0] B1 = 16'hFFFE;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ppu_vram_block_loader_if #(.ADDR_W(16), .DATA_W(8), .NUM_ENTRIES(N0)) if0 ();
   ppu_vram_block_loader_if #(.ADDR_W(16), .DATA_W(8), .NUM_ENTRIES(N1)) if1 ();

   ppu_vram_block_loader u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (if0)
   );

   ppu_vram_block_loader #(
      .NUM_ENTRIES (N1),
      .READ_LAT    (L1),
      .BASE_ADDR   (B1)
   ) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1)
   );

   // VRAM model: byte array indexed by addr[7:0], data appears READ_LAT cycles
   // after the strobe; junk is driven whenever no read is due.
   logic [7:0]  mem     [2][256];
   logic [7:0]  exp_mem [2][32];
   logic [16:0] p0 [L0];
   logic [16:0] p1 [L1];
   logic [7:0]  junk;

   always @(posedge clk) begin
      junk  <= 8'($urandom);
      p0[0] <= {if0.vram_rd, if0.vram_addr};
      for (int j = 1; j < L0; j++) p0[j] <= p0[j-1];
      p1[0] <= {if1.vram_rd, if1.vram_addr};
      for (int j = 1; j < L1; j++) p1[j] <= p1[j-1];
   end

   assign if0.vram_data_in = p0[L0-1][16] ? mem[0][p0[L0-1][7:0]] : junk;
   assign if1.vram_data_in = p1[L1-1][16] ? mem[1][p1[L1-1][7:0]] : junk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_in(input int sel, input logic start, input logic abort);
      if (sel == 0) begin
         if0.start = start;
         if0.abort = abort;
      end else begin
         if1.start = start;
         if1.abort = abort;
      end
   endtask

   task automatic get_obs(input int sel, output logic rd, output logic busy,
                          output logic done, output logic [15:0] addr);
      if (sel == 0) begin
         rd = if0.vram_rd; busy = if0.busy; done = if0.done; addr = if0.vram_addr;
      end else begin
         rd = if1.vram_rd; busy = if1.busy; done = if1.done; addr = if1.vram_addr;
      end
   endtask

   function automatic logic [7:0] obs_entry(input int sel, input int i);
      if (sel == 0) return if0.entries[i*8 +: 8];
      return if1.entries[i*8 +: 8];
   endfunction

   function automatic logic [7:0] exp_slot(input int sel, input int s);
      int n;
      n = (sel == 0) ? N0 : N1;
`ifdef PALETTE_MIRROR_EN
      if ((n >= 32) && (s >= 16) && (s <= 28) && ((s % 4) == 0)) return exp_mem[sel][s-16];
`endif
      return exp_mem[sel][s];
   endfunction

   task automatic fill_mem(input int sel);
      for (int a = 0; a < 256; a++) mem[sel][a] = 8'($urandom);
   endtask

   task automatic check_entries(input int sel, input string tag);
      int n;
      n = (sel == 0) ? N0 : N1;
      for (int i = 0; i < n; i++) check_val($sformatf("%s_entry%0d", tag, i), obs_entry(sel, i), exp_slot(sel, i));
   endtask

   // Caller is in "cycle 0" (1 time unit past an edge). Start is raised now;
   // abort_at>0 raises abort during that cycle; hold keeps start high throughout.
   task automatic run_load(input int sel, input int abort_at, input bit hold, input bit abort_with_start);
      int          n;
      int          l;
      logic [15:0] base;
      logic        rd, busy, done;
      logic [15:0] addr;
      logic [15:0] ea;
      int          last_rd, last_busy, n_new;
      bit          aborted;
      n        = (sel == 0) ? N0 : N1;
      l        = (sel == 0) ? L0 : L1;
      base     = (sel == 0) ? B0 : B1;
      aborted  = (abort_at > 0);
      last_rd   = aborted ? ((abort_at < n) ? abort_at : n) : n;
      last_busy = aborted ? ((abort_at < n + l) ? abort_at : n + l) : n + l;
      n_new     = aborted ? abort_at - l : n;
      if (n_new < 0) n_new = 0;
      if (n_new > n) n_new = n;
      set_in(sel, 1'b1, abort_with_start);
      for (int c = 1; c <= n + l + 1; c++) begin
         @(posedge clk);
         #1;
         get_obs(sel, rd, busy, done, addr);
         check_val($sformatf("dut%0d_rd_c%0d", sel, c), rd, (c <= last_rd));
         check_val($sformatf("dut%0d_busy_c%0d", sel, c), busy, (c <= last_busy));
         check_val($sformatf("dut%0d_done_c%0d", sel, c), done, ((c == n + l + 1) && !aborted));
         if (c <= last_rd) begin
            ea = base + 16'(c - 1);
            check_val($sformatf("dut%0d_addr_c%0d", sel, c), addr, ea);
         end
         set_in(sel, hold, (c == abort_at));
      end
      for (int i = 0; i < n_new; i++) begin
         ea = base + 16'(i);
         exp_mem[sel][i] = mem[sel][ea[7:0]];
      end
      check_entries(sel, $sformatf("dut%0d", sel));
      $display("load dut%0d abort_at=%0d hold=%0d abort_with_start=%0d new_entries=%0d",
               sel, abort_at, hold, abort_with_start, n_new);
   endtask

   task automatic check_reset_state(input string tag);
      check_val({tag, "_busy0"}, if0.busy, 1'b0);
      check_val({tag, "_done0"}, if0.done, 1'b0);
      check_val({tag, "_rd0"},   if0.vram_rd, 1'b0);
      check_val({tag, "_addr0"}, if0.vram_addr, 16'h0000);
      check_val({tag, "_busy1"}, if1.busy, 1'b0);
      check_val({tag, "_done1"}, if1.done, 1'b0);
      check_val({tag, "_rd1"},   if1.vram_rd, 1'b0);
      check_val({tag, "_addr1"}, if1.vram_addr, 16'h0000);
      for (int i = 0; i < 32; i++) begin
         exp_mem[0][i] = 8'h00;
         exp_mem[1][i] = 8'h00;
      end
      check_entries(0, {tag, "_d0"});
      check_entries(1, {tag, "_d1"});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int sel, n, l, ab;
      set_in(0, 1'b0, 1'b0);
      set_in(1, 1'b0, 1'b0);
      for (int a = 0; a < 256; a++) mem[0][a] = 8'(a) ^ 8'hA5;
      fill_mem(1);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("reset");
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Palette default load; entry 5 = 8'h05 ^ 8'hA5.
      run_load(0, 0, 1'b0, 1'b0);
      check_val("dut0_entry5_fixed", obs_entry(0, 5), 8'hA0);

      // Wrapping base, three-cycle read latency.
      run_load(1, 0, 1'b0, 1'b0);

      // Abort after 10 reads issued, over old contents.
      fill_mem(0);
      run_load(0, 10, 1'b0, 1'b0);

      // Abort together with start in IDLE: start wins.
      fill_mem(1);
      run_load(1, 0, 1'b0, 1'b1);

      // Start held high: one load, then a second begins from the done cycle.
      fill_mem(0);
      run_load(0, 0, 1'b1, 1'b0);
      fill_mem(0);
      run_load(0, 0, 1'b0, 1'b0);

      // Randomized loads with random aborts.
      for (int k = 0; k < 10; k++) begin
         sel = int'($urandom_range(0, 1));
         n   = (sel == 0) ? N0 : N1;
         l   = (sel == 0) ? L0 : L1;
         ab  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, n + l)) : 0;
         fill_mem(sel);
         run_load(sel, ab, 1'b0, 1'b0);
      end

      // Backdrop mirror: byte 0 = 0F, byte 16 = 30.
      fill_mem(0);
      mem[0][8'h00] = 8'h0F;
      mem[0][8'h10] = 8'h30;
      run_load(0, 0, 1'b0, 1'b0);
`ifdef PALETTE_MIRROR_EN
      check_val("dut0_slot16_mirror", obs_entry(0, 16), 8'h0F);
`else
      check_val("dut0_slot16_direct", obs_entry(0, 16), 8'h30);
`endif

      // Reset mid-load clears everything at once; a restart loads cleanly.
      fill_mem(0);
      set_in(0, 1'b1, 1'b0);
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk);
         #1;
         set_in(0, 1'b0, 1'b0);
      end
      check_val("dut0_busy_before_rst", if0.busy, 1'b1);
      #1;
      rst = 1'b0;
      #1;
      check_reset_state("midrst");
      $display("reset asserted mid-load on dut0");
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      fill_mem(0);
      run_load(0, 0, 1'b0, 1'b0);
      fill_mem(1);
      run_load(1, 0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
